gmii_rx_frame_ctrl: RTL and testbench
=====================================

# gmii_rx_frame_ctrl

Per-port GMII receive frame controller in the gmii_rx_clk domain, placed between the PHY-side GMII receive pins and the GMII-to-AXI packer. Strips preamble/SFD, admits or rejects whole frames based on `rx_en`, enforces a minimum inter-frame gap and a maximum frame length, and presents a cleaned byte stream (`gmii_rx_dv`/`gmii_rxd`) to the packer. Also keeps per-port frame statistics.

## Interface
- `MIN_IFG`, default 4: idle cycles (`dv_in` low) required after a frame before a new frame is accepted.
- `MAX_FRAME`, default 1522: maximum forwarded bytes per frame (post-SFD).
- `MAX_PREAMBLE`, default 7: maximum 0x55 bytes accepted before SFD.

Ports:
- `gmii_rx_clk`  in  1  receive clock (2.5/25/125 MHz).
- `rst_n`  in  1  reset: asynchronous, active-low; the clock is `gmii_rx_clk`.
- `rx_en`  in  1  port enable; sampled only at frame start.
- `clear_stats`  in  1  synchronous clear of `frame_cnt`/`drop_cnt`.
- `gmii_rx_dv_in`  in  1  raw PHY data valid.
- `gmii_rxd_in`  in  8  raw PHY data.
- `gmii_rx_er_in`  in  1  PHY receive error.
- `gmii_rx_dv`  out  1  cleaned data valid to the packer.
- `gmii_rxd`  out  8  cleaned data to the packer.
- `frame_done`  out  1  one-cycle pulse when a forwarded frame ends.
- `frame_len`  out  16  byte count of the last forwarded frame; valid from `frame_done` until the next `frame_done`.
- `frame_err`  out  1  qualified by `frame_done`: `rx_er` was seen or the frame was truncated.
- `err_oversize`  out  1  one-cycle pulse when truncation occurs.
- `frame_cnt`  out  16  forwarded frames, saturating at 0xFFFF.
- `drop_cnt`  out  16  dropped frames, saturating at 0xFFFF.

## Operation
FSM states: IDLE, PREAMBLE, FORWARD, DISCARD, GAP.
- **IDLE**
  - On `dv_in`=1 with `rx_en`=1: byte 0x55 → PREAMBLE (preamble count = 1); byte 0xD5 → FORWARD.
  - On `dv_in`=1 with any other byte: → DISCARD and drop.
  - On `dv_in`=1 with `rx_en`=0: → DISCARD and drop.
- **PREAMBLE**
  - 0x55: increment the preamble count. If the count exceeds `MAX_PREAMBLE` → DISCARD and drop.
  - 0xD5 → FORWARD. The SFD byte is never forwarded.
  - Any other byte → DISCARD and drop.
  - `dv_in` falling → GAP and drop.
- **FORWARD**
  - Each input byte is forwarded and the length counter increments.
  - `rx_er_in`=1 sets a sticky error flag; the byte is still forwarded.
  - `dv_in` falling → GAP. Pulse `frame_done`, latch `frame_len`, set `frame_err` from the sticky flag, increment `frame_cnt`.
  - If the length reaches `MAX_FRAME` while `dv_in`=1: stop forwarding, pulse `err_oversize`, → DISCARD.
    - `frame_done` fires on that same cycle with `frame_len`=`MAX_FRAME` and `frame_err`=1.
    - `frame_cnt` increments; `drop_cnt` does not.
- **DISCARD**
  - Nothing is forwarded. Wait for `dv_in`=0, then → GAP.
- **GAP**
  - Count consecutive cycles with `dv_in`=0. After `MIN_IFG` cycles → IDLE.
  - If `dv_in` rises earlier → DISCARD and drop (frame too close).
- **"Drop"** means `drop_cnt` increments exactly once per rejected frame.
- **`rx_en` changes** mid-frame have no effect on the current frame.
- **`clear_stats`** zeroes both counters. If it coincides with an increment, clear wins.
- **Reset mid-frame**
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - If `dv_in` is still high after reset, the remainder of the frame is judged from its first byte, so a mid-payload byte normally leads to DISCARD.

## Timing
- Reset values: all outputs are 0.
- Forwarding latency: output `dv`/`rxd` are registered, so a byte on the input at cycle N appears on the output at N+1.
- The first forwarded byte is the byte after SFD.
- `gmii_rx_dv` is contiguous for the whole frame, with no holes.
- The output `gmii_rx_dv` falls one cycle after input `dv_in` falls, on the same cycle as `frame_done`.
- On truncation, `gmii_rx_dv` falls on the cycle after the `MAX_FRAME`-th output byte.
- The packer always sees at least `MIN_IFG` idle cycles between frames.
- Counters update on the cycle after the deciding event; `frame_len` is 16-bit and never wraps, because it is bounded by `MAX_FRAME`.

## Test plan
- **Normal frame:** `rx_en`=1, 7×0x55, 0xD5, 64 bytes 0x00..0x3F, then 12 idle cycles → output `dv` high for 64 cycles carrying 0x00..0x3F, the first byte 1 cycle after input. Expect `frame_done` with `frame_len`=64, `frame_err`=0, `frame_cnt`=1.
- **Disabled port:** `rx_en`=0, same frame → no output `dv`, `drop_cnt`=1, `frame_cnt`=0. Then set `rx_en`=1 mid-frame on the next frame → that frame is still dropped (`drop_cnt`=2).
- **Bad preamble:** 0x55,0x55,0x12,... → no output, `drop_cnt`+1. Separately, 9×0x55 then SFD → dropped.
- **Oversize:** `MAX_FRAME`=100, 150-byte payload → exactly 100 output bytes, `err_oversize` pulse, `frame_len`=100, `frame_err`=1.
- **Short gap:** two frames with a 2-cycle gap at `MIN_IFG`=4 → first forwarded, second dropped (`drop_cnt`=1). A third frame after a 6-cycle gap → forwarded.
- **Error and reset:** `rx_er` asserted on payload byte 10 → `frame_err`=1 at `frame_done`. Assert `rst_n`=0 at byte 20 of a frame → outputs 0 at once, and the remaining bytes are not forwarded.

Source files
------------

// File: rtl/gmii_rx_frame_ctrl.sv
// gmii_rx_frame_ctrl
// ------------------
// Per-port GMII receive frame controller (gmii_rx_clk domain). Strips the
// preamble/SFD, admits or rejects whole frames, enforces a minimum
// inter-frame gap and a maximum forwarded length, and keeps frame statistics.
//
// Ports:
//   gmii_rx_clk    in   receive clock
//   rst_n          in   asynchronous active-low reset
//   rx_en          in   port enable, sampled only on the first byte of a frame
//   clear_stats    in   synchronous clear of frame_cnt/drop_cnt (wins over increments)
//   gmii_rx_dv_in  in   raw PHY data valid
//   gmii_rxd_in    in   raw PHY data byte
//   gmii_rx_er_in  in   PHY receive error
//   gmii_rx_dv     out  cleaned data valid to the packer (registered)
//   gmii_rxd       out  cleaned data byte to the packer (registered)
//   frame_done     out  one-cycle pulse at the end of a forwarded frame
//   frame_len      out  byte count of the last forwarded frame
//   frame_err      out  error flag of the last forwarded frame (rx_er or truncated)
//   err_oversize   out  one-cycle pulse when a frame is truncated
//   frame_cnt      out  forwarded frames, saturating
//   drop_cnt       out  dropped frames, saturating
module gmii_rx_frame_ctrl #(
  parameter int unsigned MIN_IFG      = 4,
  parameter int unsigned MAX_FRAME    = 1522,
  parameter int unsigned MAX_PREAMBLE = 7
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        clear_stats,
  input  logic        gmii_rx_dv_in,
  input  logic [7:0]  gmii_rxd_in,
  input  logic        gmii_rx_er_in,
  output logic        gmii_rx_dv,
  output logic [7:0]  gmii_rxd,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        frame_err,
  output logic        err_oversize,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_FORWARD  = 3'd2;
  localparam logic [2:0] ST_DISCARD  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;
  localparam logic [15:0] MAX_FRAME_C = 16'(MAX_FRAME);
  localparam logic [15:0] MIN_IFG_C   = 16'(MIN_IFG);
  localparam logic [7:0]  MAX_PRE_C   = 8'(MAX_PREAMBLE);

  logic [2:0]  state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;

  logic        fwd_s, done_s, trunc_s, drop_s;

  logic        rx_dv_q;
  logic [7:0]  rxd_q;
  logic        frame_done_q, frame_err_q, err_oversize_q;
  logic [15:0] frame_len_q, frame_cnt_q, drop_cnt_q;

  // Next-state and per-cycle event decode for the frame FSM.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    err_d     = err_q;
    gap_cnt_d = gap_cnt_q;
    fwd_s     = 1'b0;
    done_s    = 1'b0;
    trunc_s   = 1'b0;
    drop_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv_in) begin
          len_d = 16'd0;
          err_d = 1'b0;
          if (rx_en && (gmii_rxd_in == BYTE_PRE)) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 8'd1;
          end else if (rx_en && (gmii_rxd_in == BYTE_SFD)) begin
            state_d = ST_FORWARD;
          end else begin
            state_d = ST_DISCARD;
            drop_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv_in) begin
          state_d   = ST_GAP;
          gap_cnt_d = 16'd1;
          drop_s    = 1'b1;
        end else if (gmii_rxd_in == BYTE_PRE) begin
          // Count would exceed the limit with this byte.
          if (pre_cnt_q >= MAX_PRE_C) begin
            state_d = ST_DISCARD;
            drop_s  = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end else if (gmii_rxd_in == BYTE_SFD) begin
          state_d = ST_FORWARD;
        end else begin
          state_d = ST_DISCARD;
          drop_s  = 1'b1;
        end
      end
      ST_FORWARD: begin
        if (!gmii_rx_dv_in) begin
          state_d   = ST_GAP;
          gap_cnt_d = 16'd1;
          done_s    = 1'b1;
        end else if (len_q >= MAX_FRAME_C) begin
          // MAX_FRAME bytes already forwarded and the frame continues.
          state_d = ST_DISCARD;
          done_s  = 1'b1;
          trunc_s = 1'b1;
        end else begin
          fwd_s = 1'b1;
          len_d = len_q + 16'd1;
          err_d = err_q | gmii_rx_er_in;
        end
      end
      ST_DISCARD: begin
        if (!gmii_rx_dv_in) begin
          state_d   = ST_GAP;
          gap_cnt_d = 16'd1;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_GAP: begin
        if (gmii_rx_dv_in) begin
          state_d = ST_DISCARD;
          drop_s  = 1'b1;
        end else if ((gap_cnt_q + 16'd1) >= MIN_IFG_C) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 16'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and frame bookkeeping registers.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= 8'd0;
      len_q     <= 16'd0;
      err_q     <= 1'b0;
      gap_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Registered byte stream and end-of-frame reporting.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dv_q        <= 1'b0;
      rxd_q          <= 8'h00;
      frame_done_q   <= 1'b0;
      frame_len_q    <= 16'd0;
      frame_err_q    <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      rx_dv_q        <= fwd_s;
      rxd_q          <= fwd_s ? gmii_rxd_in : 8'h00;
      frame_done_q   <= done_s;
      err_oversize_q <= trunc_s;
      if (done_s) begin
        frame_len_q <= len_q;
        frame_err_q <= trunc_s | err_q;
      end
    end
  end

  // Saturating statistics; clear_stats takes priority over an increment.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else if (clear_stats) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (done_s && (frame_cnt_q != 16'hFFFF)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign gmii_rx_dv   = rx_dv_q;
  assign gmii_rxd     = rxd_q;
  assign frame_done   = frame_done_q;
  assign frame_len    = frame_len_q;
  assign frame_err    = frame_err_q;
  assign err_oversize = err_oversize_q;
  assign frame_cnt    = frame_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed testbench for gmii_rx_frame_ctrl (MIN_IFG=4, MAX_FRAME=100,
// MAX_PREAMBLE=7). Inputs change on the falling edge; a falling-edge monitor
// logs the output byte stream and end-of-frame reports.
module tb_gmii_rx_frame_ctrl;

  logic        gmii_rx_clk;
  logic        rst_n;
  logic        rx_en;
  logic        clear_stats;
  logic        gmii_rx_dv_in;
  logic [7:0]  gmii_rxd_in;
  logic        gmii_rx_er_in;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;
  logic        err_oversize;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  gmii_rx_frame_ctrl #(
    .MIN_IFG      (4),
    .MAX_FRAME    (100),
    .MAX_PREAMBLE (7)
  ) dut (
    .gmii_rx_clk   (gmii_rx_clk),
    .rst_n         (rst_n),
    .rx_en         (rx_en),
    .clear_stats   (clear_stats),
    .gmii_rx_dv_in (gmii_rx_dv_in),
    .gmii_rxd_in   (gmii_rxd_in),
    .gmii_rx_er_in (gmii_rx_er_in),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rxd      (gmii_rxd),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .frame_err     (frame_err),
    .err_oversize  (err_oversize),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial gmii_rx_clk = 1'b0;
  always #5 gmii_rx_clk = ~gmii_rx_clk;

  int cyc = 0;
  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  // Output monitor
  int         mon_out_n = 0;
  int         mon_done_n = 0;
  int         mon_ovs_n = 0;
  int         mon_rise_n = 0;
  int         mon_misalign_n = 0;
  logic [7:0] mon_bytes [0:1023];
  int         mon_rise_cyc [0:63];
  logic [15:0] mon_len = 16'd0;
  logic       mon_err = 1'b0;
  logic       prev_dv = 1'b0;

  always @(negedge gmii_rx_clk) begin
    if (gmii_rx_dv === 1'b1) begin
      if (mon_out_n < 1024) mon_bytes[mon_out_n] = gmii_rxd;
      mon_out_n++;
      if (!prev_dv) begin
        if (mon_rise_n < 64) mon_rise_cyc[mon_rise_n] = cyc;
        mon_rise_n++;
      end
    end
    if (frame_done === 1'b1) begin
      mon_done_n++;
      mon_len = frame_len;
      mon_err = frame_err;
      if (!(prev_dv && (gmii_rx_dv === 1'b0))) mon_misalign_n++;
    end
    if (err_oversize === 1'b1) begin
      mon_ovs_n++;
      if (frame_done !== 1'b1) mon_misalign_n++;
    end
    prev_dv = (gmii_rx_dv === 1'b1);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(negedge gmii_rx_clk);
    gmii_rx_dv_in = dv;
    gmii_rxd_in   = d;
    gmii_rx_er_in = er;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int npre, input int npay, input logic [7:0] start,
                            input int er_idx, output int first_cyc);
    first_cyc = 0;
    for (int k = 0; k < npre; k++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < npay; k++) begin
      drive(1'b1, start + 8'(k), (k == er_idx));
      if (k == 0) first_cyc = cyc;
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input int n, input logic [7:0] start);
    for (int k = 0; k < n; k++)
      check(tag, 32'(mon_bytes[base + k]), 32'(start + 8'(k)));
  endtask

  int b_out, b_done, b_rise, b_ovs, fc;

  task automatic mark();
    #1;
    b_out  = mon_out_n;
    b_done = mon_done_n;
    b_rise = mon_rise_n;
    b_ovs  = mon_ovs_n;
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; clear_stats = 1'b0;
    gmii_rx_dv_in = 1'b0; gmii_rxd_in = 8'h00; gmii_rx_er_in = 1'b0;
    idle(3);
    #1;
    check("rst_dv",   32'(gmii_rx_dv),   32'd0);
    check("rst_rxd",  32'(gmii_rxd),     32'd0);
    check("rst_done", 32'(frame_done),   32'd0);
    check("rst_len",  32'(frame_len),    32'd0);
    check("rst_err",  32'(frame_err),    32'd0);
    check("rst_ovs",  32'(err_oversize), 32'd0);
    check("rst_fcnt", 32'(frame_cnt),    32'd0);
    check("rst_dcnt", 32'(drop_cnt),     32'd0);
    @(negedge gmii_rx_clk); rst_n = 1'b1;
    idle(3);

    // Normal frame
    rx_en = 1'b1;
    mark();
    send_frame(7, 64, 8'h00, -1, fc);
    idle(12);
    mark();
    check("norm_nbytes", 32'(mon_out_n - 0), 32'd64);
    check_bytes("norm_data", 0, 64, 8'h00);
    check("norm_latency", 32'(mon_rise_cyc[0]), 32'(fc + 1));
    check("norm_rises", 32'(mon_rise_n), 32'd1);
    check("norm_done",  32'(mon_done_n), 32'd1);
    check("norm_len",   32'(mon_len), 32'd64);
    check("norm_err",   32'(mon_err), 32'd0);
    check("norm_fcnt",  32'(frame_cnt), 32'd1);
    check("norm_dcnt",  32'(drop_cnt), 32'd0);

    // Statistics clear
    drive(1'b0, 8'h00, 1'b0); clear_stats = 1'b1;
    drive(1'b0, 8'h00, 1'b0); clear_stats = 1'b0;
    #1;
    check("clr_fcnt", 32'(frame_cnt), 32'd0);

    // Disabled port, then enable mid-frame
    rx_en = 1'b0;
    mark();
    send_frame(7, 64, 8'h00, -1, fc);
    idle(12);
    #1;
    check("dis_dcnt", 32'(drop_cnt), 32'd1);
    check("dis_fcnt", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'h55, 1'b0);
    rx_en = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < 64; k++) drive(1'b1, 8'(k), 1'b0);
    idle(12);
    #1;
    check("dis_mid_dcnt", 32'(drop_cnt), 32'd2);
    check("dis_nbytes", 32'(mon_out_n - b_out), 32'd0);

    // Bad preamble byte, then overlong preamble
    mark();
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h12, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 8'(k), 1'b0);
    idle(12);
    #1;
    check("badpre_dcnt", 32'(drop_cnt), 32'd3);
    send_frame(9, 20, 8'h00, -1, fc);
    idle(12);
    #1;
    check("longpre_dcnt", 32'(drop_cnt), 32'd4);
    check("pre_nbytes", 32'(mon_out_n - b_out), 32'd0);
    check("pre_fcnt", 32'(frame_cnt), 32'd0);

    // Oversize: 150-byte payload truncated at 100
    mark();
    send_frame(7, 150, 8'h00, -1, fc);
    idle(12);
    #1;
    check("ovs_nbytes", 32'(mon_out_n - b_out), 32'd100);
    check_bytes("ovs_data", b_out, 100, 8'h00);
    check("ovs_rises", 32'(mon_rise_n - b_rise), 32'd1);
    check("ovs_pulse", 32'(mon_ovs_n - b_ovs), 32'd1);
    check("ovs_done",  32'(mon_done_n - b_done), 32'd1);
    check("ovs_len",   32'(mon_len), 32'd100);
    check("ovs_err",   32'(mon_err), 32'd1);
    check("ovs_fcnt",  32'(frame_cnt), 32'd1);
    check("ovs_dcnt",  32'(drop_cnt), 32'd4);

    // Short gap (2) drops, 6-cycle gap and exact 4-cycle gap accepted
    mark();
    send_frame(7, 20, 8'h40, -1, fc);
    idle(2);
    send_frame(7, 20, 8'h80, -1, fc);
    idle(6);
    send_frame(7, 20, 8'hC0, -1, fc);
    idle(4);
    send_frame(7, 20, 8'h10, -1, fc);
    idle(12);
    #1;
    check("gap_nbytes", 32'(mon_out_n - b_out), 32'd60);
    check_bytes("gap_a", b_out, 20, 8'h40);
    check_bytes("gap_c", b_out + 20, 20, 8'hC0);
    check_bytes("gap_d", b_out + 40, 20, 8'h10);
    check("gap_rises", 32'(mon_rise_n - b_rise), 32'd3);
    check("gap_done",  32'(mon_done_n - b_done), 32'd3);
    check("gap_fcnt",  32'(frame_cnt), 32'd4);
    check("gap_dcnt",  32'(drop_cnt), 32'd5);

    // rx_er on payload byte 10
    mark();
    send_frame(7, 30, 8'h00, 10, fc);
    idle(12);
    #1;
    check("er_nbytes", 32'(mon_out_n - b_out), 32'd30);
    check("er_done", 32'(mon_done_n - b_done), 32'd1);
    check("er_len",  32'(mon_len), 32'd30);
    check("er_err",  32'(mon_err), 32'd1);
    check("er_fcnt", 32'(frame_cnt), 32'd5);

    // Reset asserted during payload byte 20
    mark();
    send_frame(7, 20, 8'h00, -1, fc);
    drive(1'b1, 8'd20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_dv",   32'(gmii_rx_dv), 32'd0);
    check("mrst_rxd",  32'(gmii_rxd),   32'd0);
    check("mrst_fcnt", 32'(frame_cnt),  32'd0);
    check("mrst_len",  32'(frame_len),  32'd0);
    check("mrst_err",  32'(frame_err),  32'd0);
    drive(1'b1, 8'd21, 1'b0);
    drive(1'b1, 8'd22, 1'b0);
    drive(1'b1, 8'd23, 1'b0);
    rst_n = 1'b1;
    for (int k = 24; k < 40; k++) drive(1'b1, 8'(k), 1'b0);
    idle(12);
    #1;
    check("mrst_nbytes", 32'(mon_out_n - b_out), 32'd20);
    check_bytes("mrst_data", b_out, 20, 8'h00);
    check("mrst_done", 32'(mon_done_n - b_done), 32'd0);
    check("mrst_dcnt", 32'(drop_cnt), 32'd1);

    // clear_stats on the same cycle as a frame_cnt increment
    mark();
    send_frame(7, 8, 8'hA0, -1, fc);
    drive(1'b0, 8'h00, 1'b0); clear_stats = 1'b1;
    drive(1'b0, 8'h00, 1'b0); clear_stats = 1'b0;
    idle(12);
    #1;
    check("clrw_nbytes", 32'(mon_out_n - b_out), 32'd8);
    check_bytes("clrw_data", b_out, 8, 8'hA0);
    check("clrw_done", 32'(mon_done_n - b_done), 32'd1);
    check("clrw_len",  32'(mon_len), 32'd8);
    check("clrw_fcnt", 32'(frame_cnt), 32'd0);
    check("clrw_dcnt", 32'(drop_cnt), 32'd0);

    check("done_alignment", 32'(mon_misalign_n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
